gcd_job_arbiter: RTL
====================

// Module: gcd_job_arbiter
// PURPOSE
//   Shares one iterative subtract-based GCD engine among N_REQ requesters.
//   Round-robin arbitration, one job in flight at a time.
//   Sits between requester logic and the engine: latches operands,
//   pulses engine start, waits for engine done, routes the result back.
// PARAMETERS
//   N_REQ  4  number of requesters (2..8)
//   DW     8  operand/result width; matches engine a/b/gcd width
// PORTS
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req_valid  in   N_REQ     per-requester job request; held until accepted
//   req_a      in   N_REQ*DW  operand a, slice i = [i*DW +: DW]
//   req_b      in   N_REQ*DW  operand b, same slicing
//   req_ready  out  N_REQ     one-hot accept pulse; transfer = valid & ready
//   rsp_valid  out  N_REQ     one-hot, one-cycle result strobe to job owner
//   rsp_gcd    out  DW        result; valid only while rsp_valid != 0
//   eng_start  out  1         one-cycle start pulse to engine
//   eng_a      out  DW        latched operand a; stable from start to done
//   eng_b      out  DW        latched operand b; stable from start to done
//   eng_done   in   1         engine completion pulse
//   eng_gcd    in   DW        engine result, sampled when eng_done=1
// BEHAVIOUR
//   Reset: state=IDLE, rr pointer=0, owner=0, op/result regs=0;
//     all outputs 0 (req_ready, rsp_valid, eng_start, eng_a/b, rsp_gcd).
//   FSM: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
//   IDLE: if |req_valid, pick winner i = first set bit scanning from
//     rr_ptr upward with wrap; req_ready[i]=1 this cycle (combinational);
//     latch req_a/req_b slice i and owner=i at the edge; go ISSUE.
//     No request: stay IDLE, all strobes 0.
//   ISSUE: eng_start=1 for exactly one cycle; go BUSY.
//   BUSY: hold eng_a/eng_b; on eng_done capture eng_gcd, go RESP.
//     No timeout; waits indefinitely.
//   RESP: rsp_valid[owner]=1, rsp_gcd=captured result, one cycle;
//     rr_ptr = (owner+1) mod N_REQ; go IDLE.
//   Latency: accept at cycle 0, start at cycle 1, response one cycle
//     after the cycle eng_done is seen.
//   Throughput: at most one accept per job; no accept outside IDLE.
//   Fairness: a continuously requesting requester is served within
//     N_REQ jobs.
//   Simultaneous events: req_valid rising during ISSUE/BUSY/RESP is
//     held off until the next IDLE. An eng_done seen outside BUSY is
//     ignored.
//   Reset mid-operation: job is dropped, no rsp_valid, FSM to IDLE.
//     Engine is reset separately by the same rst_n.
//   Widths: no arithmetic here; results pass through unmodified.
//   State encoding: 2 bits, default branch returns to IDLE.
// CONFIGURATION
//   GCD_ZERO_BYPASS_EN defined: on accept, if a==0 or b==0, skip the
//     engine and go IDLE -> RESP directly with result = a|b
//     (gcd(0,x)=x, gcd(0,0)=0). eng_start is never pulsed for that job;
//     response arrives the cycle after accept.
//   Undefined: every job, including zero operands, goes through the
//     engine via ISSUE/BUSY.
// STRUCTURE
//   Package gcd_arb_pkg: state enum (IDLE, ISSUE, BUSY, RESP),
//     default DW/N_REQ localparams, clog2-based owner index width.
//   Sub-module gcd_rr_arbiter: round-robin pointer + masked priority
//     pick; outputs one-hot grant and binary index. Pointer advances
//     only on RESP.
// TESTING
//   1 req_valid[0], a=12, b=18; engine model done after 5 cycles
//     -> req_ready[0] one cycle, eng_start one cycle,
//        rsp_valid=4'b0001, rsp_gcd=6.
//   2 all four request at once (a=8*k, b=12) -> served in order 0,1,2,3;
//     each gets exactly one rsp_valid; next round starts at 0.
//   3 req 2 active, then req 1 asserts during BUSY -> req 1 waits, is
//     granted next IDLE; eng_a/eng_b stable across BUSY.
//   4 rst_n low during BUSY -> no rsp_valid; outputs 0 asynchronously;
//     a new job after reset completes normally.
//   5 a=0, b=35 -> with GCD_ZERO_BYPASS_EN: no eng_start, rsp_gcd=35
//     one cycle after accept; without it: eng_start pulses, rsp_gcd=35.
//   6 spurious eng_done in IDLE -> ignored, no rsp_valid.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
// Shared types and sizing helpers for the GCD job arbiter and its
// round-robin picker.
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 8;

  // Index width that stays at least one bit wide even for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_N_REQ);

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Round-robin picker: scans from the pointer upward with wrap and returns a
// one-hot grant plus its binary index. The pointer moves past the last owner.
module gcd_rr_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  input  logic [IW-1:0]    last_idx_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   pos;

  // Walk from the farthest slot back toward the pointer so the closest hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (IW+1)'(k);
      if (pos >= (IW+1)'(N_REQ)) begin
        pos = pos - (IW+1)'(N_REQ);
      end
      if (req_i[pos[IW-1:0]]) begin
        grant_o = N_REQ'(1) << pos[IW-1:0];
        idx_o   = pos[IW-1:0];
        any_o   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (last_idx_i == IW'(N_REQ - 1)) ? '0 : last_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one GCD engine among N_REQ requesters, one job in flight at a time.
// Optional GCD_ZERO_BYPASS_EN answers zero-operand jobs without the engine.
module gcd_job_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_gcd,
  output logic                eng_start,
  output logic [DW-1:0]       eng_a,
  output logic [DW-1:0]       eng_b,
  input  logic                eng_done,
  input  logic [DW-1:0]       eng_gcd
);

  localparam int IW = idx_w(N_REQ);

  state_e             state_q;
  logic [IW-1:0]      owner_q;
  logic [DW-1:0]      op_a_q, op_b_q, result_q;
  logic               eng_start_q;
  logic [N_REQ-1:0]   rsp_valid_q;

  logic [N_REQ-1:0]   grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic               accept;
  logic [DW-1:0]      sel_a, sel_b;
  logic [N_REQ-1:0]   owner_onehot;

  gcd_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_valid),
    .advance_i  (state_q == RESP),
    .last_idx_i (owner_q),
    .grant_o    (grant),
    .idx_o      (grant_idx),
    .any_o      (grant_any)
  );

  // The accept strobe is combinational, so it is also masked while reset is held.
  assign accept    = (state_q == IDLE) && grant_any && rst_n;
  assign req_ready = accept ? grant : '0;

  assign sel_a = req_a[grant_idx*DW +: DW];
  assign sel_b = req_b[grant_idx*DW +: DW];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner
    assign owner_onehot[gi] = (owner_q == IW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= grant_idx;
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
`ifdef GCD_ZERO_BYPASS_EN
            if ((sel_a == '0) || (sel_b == '0)) begin
              result_q    <= sel_a | sel_b;
              rsp_valid_q <= grant;
              state_q     <= RESP;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
`else
            eng_start_q <= 1'b1;
            state_q     <= ISSUE;
`endif
          end
        end
        ISSUE: state_q <= BUSY;
        BUSY: begin
          if (eng_done) begin
            result_q    <= eng_gcd;
            rsp_valid_q <= owner_onehot;
            state_q     <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_start = eng_start_q;
  assign eng_a     = op_a_q;
  assign eng_b     = op_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_gcd   = result_q;

endmodule
